// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit seven-segment display with a shared decoder.
// Optional leading-zero suppression is enabled by defining SEG_LEAD_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              hex_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        next_idx;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] active_nxt;
  logic [NUM_DIGITS-1:0]   active_dp_nxt;
  logic                    show_end;
  logic                    boundary;
  logic                    suppress;
  logic                    lit;
  logic [6:0]              seg_lit;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   an_lit;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  // Digit i is dark when it and every digit above it are zero; digit 0 always shows.
  function automatic logic lead_zero_dark(input logic [4*NUM_DIGITS-1:0] v,
                                          input logic [IDX_W-1:0]        i);
    logic dark;
    dark = (i != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(i) && v[k*4 +: 4] != 4'h0) dark = 1'b0;
    end
    return dark;
  endfunction

  assign suppress = lead_zero_dark(active_val, idx);
`else
  assign suppress = 1'b0;
`endif

  assign show_end = (state == ST_SHOW) && (cnt == SHOW_LAST);
  assign boundary = show_end && (idx == LAST_IDX);
  assign next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  assign lit     = digit_en[idx] && !suppress;
  assign seg_lit = lit ? seg_in : '0;
  assign dp_lit  = lit && active_dp[idx];
  assign an_lit  = lit ? ~(NUM_DIGITS'(1) << idx) : '1;

  // A load landing on the frame boundary bypasses the shadow and commits directly.
  always_comb begin
    active_nxt    = active_val;
    active_dp_nxt = active_dp;
    if (boundary) begin
      if (load) begin
        active_nxt    = value;
        active_dp_nxt = dp_in;
      end else if (pending) begin
        active_nxt    = shadow_val;
        active_dp_nxt = shadow_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      active_val <= '0;
      active_dp  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      hex_out    <= 4'h0;
      seg_out    <= 7'h00;
      dp_out     <= 1'b0;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      active_val <= active_nxt;
      active_dp  <= active_dp_nxt;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (boundary)  pending <= 1'b0;
      else if (load) pending <= 1'b1;

      if (state == ST_BLANK) begin
        if (cnt == BLANK_LAST) begin
          state   <= ST_SHOW;
          cnt     <= '0;
          seg_out <= seg_lit;
          dp_out  <= dp_lit;
          an_out  <= an_lit;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (show_end) begin
          // Present the next nibble now so the decoder settles during the gap.
          state   <= ST_BLANK;
          cnt     <= '0;
          idx     <= next_idx;
          hex_out <= active_nxt[next_idx*4 +: 4];
          seg_out <= 7'h00;
          dp_out  <= 1'b0;
          an_out  <= '1;
        end else begin
          cnt     <= cnt + 1'b1;
          seg_out <= seg_lit;
          dp_out  <= dp_lit;
          an_out  <= an_lit;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-frame vector table feeding a cycle-by-cycle expectation queue.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  hex_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SHOW_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .digit_en(digit_en), .hex_out(hex_out), .seg_in(seg_in), .seg_out(seg_out),
    .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
      4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
      4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
      4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  assign seg_in = dec(hex_out);

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] hex;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        fd0;
    int          la;
    logic [15:0] lva;
    logic [3:0]  lda;
    int          lb;
    logic [15:0] lvb;
    logic [3:0]  ldb;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[9];

  task automatic cmp(input string name, input int c, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  function automatic logic lit_f(input logic [15:0] val, input logic [3:0] en, input int d);
    logic r;
    r = en[d];
`ifdef SEG_LEAD_ZERO_BLANK_EN
    if (d > 0 && (val >> (4*d)) == 16'h0000) r = 1'b0;
`endif
    return r;
  endfunction

  task automatic check_reset(input string tag);
    cmp({tag, "_an"},  0, 8'(an_out),     8'h0F);
    cmp({tag, "_seg"}, 0, 8'(seg_out),    8'h00);
    cmp({tag, "_dp"},  0, 8'(dp_out),     8'h00);
    cmp({tag, "_hex"}, 0, 8'(hex_out),    8'h00);
    cmp({tag, "_fd"},  0, 8'(frame_done), 8'h00);
  endtask

  // Called on the sampling edge of frame cycle 0; returns on cycle 0 of the next frame.
  task automatic check_frame(input vec_t v);
    exp_t       e;
    int         d;
    int         p;
    logic [3:0] oh;
    digit_en = v.en;
    for (int c = 0; c < 24; c++) begin
      d = c / 6;
      p = c % 6;
      e.hex = v.val[4*d +: 4];
      e.fd  = (c == 0) ? v.fd0 : 1'b0;
      if (p >= 2 && lit_f(v.val, v.en, d)) begin
        oh    = 4'b0001 << d;
        e.an  = ~oh;
        e.seg = dec(e.hex);
        e.dp  = v.dp[d];
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h00;
        e.dp  = 1'b0;
      end
      sbq.push_back(e);
    end
    for (int c = 0; c < 24; c++) begin
      e = sbq.pop_front();
      cmp("an_out",     c, 8'(an_out),     8'(e.an));
      cmp("seg_out",    c, 8'(seg_out),    8'(e.seg));
      cmp("dp_out",     c, 8'(dp_out),     8'(e.dp));
      cmp("hex_out",    c, 8'(hex_out),    8'(e.hex));
      cmp("frame_done", c, 8'(frame_done), 8'(e.fd));
      if (c == v.la) begin
        value = v.lva; dp_in = v.lda; load = 1'b1;
      end else if (c == v.lb) begin
        value = v.lvb; dp_in = v.ldb; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t z;
    vecs[0] = '{16'h0000, 4'b0000, 4'b1111, 1'b0,  8, 16'h1234, 4'b0100, -1, 16'h0, 4'h0};
    vecs[1] = '{16'h1234, 4'b0100, 4'b1111, 1'b1, -1, 16'h0,    4'h0,    -1, 16'h0, 4'h0};
    vecs[2] = '{16'h1234, 4'b0100, 4'b1011, 1'b1, 23, 16'hABCD, 4'b0001, -1, 16'h0, 4'h0};
    vecs[3] = '{16'hABCD, 4'b0001, 4'b1111, 1'b1,  5, 16'h1111, 4'b1111, 15, 16'h2222, 4'b0010};
    vecs[4] = '{16'h2222, 4'b0010, 4'b0110, 1'b1,  3, 16'h0040, 4'b0000, -1, 16'h0, 4'h0};
    vecs[5] = '{16'h0040, 4'b0000, 4'b1111, 1'b1,  3, 16'h0000, 4'b1111, -1, 16'h0, 4'h0};
    vecs[6] = '{16'h0000, 4'b1111, 4'b1111, 1'b1, 20, 16'h9F0E, 4'b0101, -1, 16'h0, 4'h0};
    vecs[7] = '{16'h9F0E, 4'b0101, 4'b1111, 1'b1, -1, 16'h0,    4'h0,    -1, 16'h0, 4'h0};
    vecs[8] = '{16'h9F0E, 4'b0101, 4'b1111, 1'b1, -1, 16'h0,    4'h0,    -1, 16'h0, 4'h0};

    rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'hF;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) check_frame(vecs[i]);

    // Mid-frame reset during digit 2's SHOW with an update still pending.
    for (int c = 0; c < 15; c++) begin
      if (c == 10) begin
        value = 16'h5555; dp_in = 4'b1111; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    cmp("pre_rst_an",  15, 8'(an_out),  8'h0B);
    cmp("pre_rst_seg", 15, 8'(seg_out), 8'(dec(4'hF)));
    cmp("pre_rst_dp",  15, 8'(dp_out),  8'h01);
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    z = '{16'h0000, 4'b0000, 4'b1111, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0};
    check_frame(z);
    z.fd0 = 1'b1;
    check_frame(z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-segment, N-digit seven-segment display.
- Sequences a single shared hex-to-seven-segment decoder across all digits: drives the decoder's 4-bit input, captures its 7-bit output and asserts the matching digit anode.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value so host updates never tear mid-frame.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SHOW_CYCLES, 50000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 16, clk cycles all anodes are off before each digit (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
value  in  4*NUM_DIGITS  hex value to display; nibble i = digit i, digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
load  in  1  one-cycle strobe; captures value/dp_in into the shadow register
digit_en  in  NUM_DIGITS  per-digit enable; 0 keeps that digit dark
hex_out  out  4  nibble to the shared decoder
seg_in  in  7  decoder result {a,b,c,d,e,f,g}, 1 = segment lit, combinational from hex_out
seg_out  out  7  segment drive {a..g}, 1 = lit
dp_out  out  1  decimal point drive, 1 = lit
an_out  out  NUM_DIGITS  digit anodes, active-low
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (async, rst=1) sets every state element:
  - state=BLANK, digit index idx=0, cycle counter cnt=0.
  - active and shadow registers all 0; pending=0.
  - Outputs: hex_out=0, seg_out=0, dp_out=0, an_out=all 1s, frame_done=0.
  - Reset asserted mid-frame aborts the frame immediately and discards any pending update.
- All outputs are registered.
- FSM has two states:
  - BLANK:
    - an_out all 1s, seg_out=0, dp_out=0.
    - hex_out = active nibble[idx], set on entry so the decoder settles during the gap.
    - After BLANK_CYCLES cycles, go to SHOW.
  - SHOW:
    - If digit_en[idx]=1: seg_out<=seg_in, dp_out<=active_dp[idx], an_out bit idx=0, all other bits 1.
    - If digit_en[idx]=0: outputs stay as in BLANK, but the slot still consumes SHOW_CYCLES so brightness stays uniform.
    - After SHOW_CYCLES cycles: idx<=(idx==NUM_DIGITS-1)?0:idx+1, then go to BLANK.
- Digit slot = BLANK_CYCLES+SHOW_CYCLES cycles; frame = NUM_DIGITS slots. cnt counts 0..limit-1 and resets on every state change.
- frame_done pulses high for the single cycle in which the last SHOW of idx=NUM_DIGITS-1 completes; it is registered and visible the following cycle.
- Load / double buffer:
  - load=1 captures value and dp_in into shadow and sets pending=1.
  - At the frame boundary (the cycle that asserts frame_done): if pending, active<=shadow and pending<=0.
  - load in the same cycle as the boundary: the incoming value/dp_in are committed directly to active, and pending ends 0.
  - Back-to-back loads within one frame: the last one wins.
- digit_en is sampled live at each SHOW cycle and is not buffered.
- Wrap: after idx=NUM_DIGITS-1 the scan returns to idx=0 with no idle cycles.

Optional Feature:
SEG_LEAD_ZERO_BLANK_EN
- Defined:
  - In SHOW, digit i is forced dark (as if digit_en[i]=0) when active nibble[i]==0 and all active nibbles above i are 0, for i>0.
  - Digit 0 always shows, so an all-zero value displays a single "0".
  - dp for a suppressed digit is also dark.
- Undefined: every enabled digit displays its nibble, including leading zeros.

Test Plan:
Use NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=2 (slot=6, frame=24 cycles) with the hex decoder connected.
- Reset then idle: an_out=4'b1111, seg_out=0 for the first 2 cycles after rst release; an_out=4'b1110 and seg_out=decode(0) for the next 4; frame_done every 24 cycles.
- load value=16'h1234, dp_in=4'b0100 mid-frame: display unchanged until the next frame_done; then digit0 shows 4, digit1 shows 3, digit2 shows 2 with dp_out=1, digit3 shows 1, each with the correct single low anode bit.
- digit_en=4'b1011: the digit2 slot shows an_out=4'b1111 and seg_out=0 for all 6 cycles; frame period remains 24.
- load asserted in the frame_done cycle with 16'hABCD: the next frame displays ABCD; pending=0 afterwards. Two loads in one frame (1111 then 2222): only 2222 appears.
- rst pulsed while idx=2 in SHOW: outputs go to reset values immediately; after release the scan restarts at idx=0 with active=0000.
- With SEG_LEAD_ZERO_BLANK_EN and value=16'h0040: digits 3 and 2 are dark, digits 1 and 0 show 4 and 0. With value=16'h0000: only digit0 shows 0.
